// File: rtl/radix2_pkg.sv
// radix2_pkg -- shared definitions for the 4-point radix-2 inverse FFT.
//
// Contents:
//   N          transform length (4 points)
//   CNT_W      width of the bin/sample index counter
//   DEF_IN_W   default signed width of an input bin component
//   DEF_OUT_W  default signed width of an output sample component
//   state_e    control states LOAD / CALC / OUT
//   cplx_t     complex sample (real/imag) at the default output width
package radix2_pkg;

  localparam int N         = 4;
  localparam int CNT_W     = $clog2(N);
  localparam int DEF_IN_W  = 4;
  localparam int DEF_OUT_W = DEF_IN_W + 2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DEF_OUT_W-1:0] re;
    logic signed [DEF_OUT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/radix2_bfly.sv
// radix2_bfly -- one complex add/subtract butterfly.
//
// Ports:
//   a_re, a_im     in  W    signed first operand
//   b_re, b_im     in  W    signed second operand
//   sum_re, sum_im out W+1  a + b, one guard bit so no overflow
//   dif_re, dif_im out W+1  a - b, one guard bit so no overflow
//
// Any twiddle rotation is applied by the caller before b enters.
module radix2_bfly #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W:0]   sum_re,
  output logic signed [W:0]   sum_im,
  output logic signed [W:0]   dif_re,
  output logic signed [W:0]   dif_im
);

  // Operands are sign-extended by one bit before the add/subtract.
  assign sum_re = (W+1)'(a_re) + (W+1)'(b_re);
  assign sum_im = (W+1)'(a_im) + (W+1)'(b_im);
  assign dif_re = (W+1)'(a_re) - (W+1)'(b_re);
  assign dif_im = (W+1)'(a_im) - (W+1)'(b_im);

endmodule

// File: rtl/radix2ifft.sv
// radix2ifft -- 4-point radix-2 inverse DFT with valid/ready streaming.
//
// Ports:
//   clk             in   1      rising-edge clock
//   rst_n           in   1      asynchronous active-low reset
//   in_valid        in   1      bin present on in_re/in_im
//   in_ready        out  1      block accepts a bin this cycle (LOAD)
//   in_re, in_im    in   IN_W   signed bin X[k], k = 0..3 in order
//   out_valid       out  1      time sample present on out_re/out_im
//   out_ready       in   1      sink accepts a sample this cycle
//   out_re, out_im  out  OUT_W  signed time sample x[n], n = 0..3
//   out_last        out  1      high with sample n = 3
//
// Build option:
//   RADIX2IFFT_SCALE_EN  when defined, every output is x[n] >>> 2
//                        (divide by N, floor); otherwise unscaled.
//
// Flow: four bins are captured in LOAD, the two butterfly stages are
// registered into the output buffer in CALC, then OUT streams the buffer.
// All outputs are registers; on entry to OUT the first cycle loads the
// output registers, so out_valid rises two edges after bin 3 is captured.
module radix2ifft
  import radix2_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = IN_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    out_last
);

  localparam int S1_W   = IN_W + 1;
  localparam int FULL_W = IN_W + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;

  logic signed [IN_W-1:0]  bin_re_r [N];
  logic signed [IN_W-1:0]  bin_im_r [N];
  logic signed [OUT_W-1:0] buf_re_r [N];
  logic signed [OUT_W-1:0] buf_im_r [N];

  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic signed [OUT_W-1:0] out_re_r;
  logic signed [OUT_W-1:0] out_im_r;

  logic                    in_fire_s;
  logic                    out_fire_s;

  // Stage 1 results
  logic signed [S1_W-1:0]  a0_re_s, a0_im_s, a1_re_s, a1_im_s;
  logic signed [S1_W-1:0]  b0_re_s, b0_im_s, b1_re_s, b1_im_s;
  // b1 rotated by +j: (re, im) -> (-im, re)
  logic signed [S1_W-1:0]  jb1_re_s, jb1_im_s;
  // Stage 2 results
  logic signed [FULL_W-1:0] x0_re_s, x0_im_s, x1_re_s, x1_im_s;
  logic signed [FULL_W-1:0] x2_re_s, x2_im_s, x3_re_s, x3_im_s;

  logic signed [FULL_W-1:0] full_re_s [N];
  logic signed [FULL_W-1:0] full_im_s [N];
  logic signed [OUT_W-1:0]  res_re_s  [N];
  logic signed [OUT_W-1:0]  res_im_s  [N];

  assign in_fire_s  = in_valid && in_ready_r;
  assign out_fire_s = out_valid_r && out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_re    = out_re_r;
  assign out_im    = out_im_r;

  // ---------------------------------------------------------------------
  // Butterfly datapath
  // ---------------------------------------------------------------------
  radix2_bfly #(.W(IN_W)) u_s1_even (
    .a_re  (bin_re_r[0]), .a_im  (bin_im_r[0]),
    .b_re  (bin_re_r[2]), .b_im  (bin_im_r[2]),
    .sum_re(a0_re_s),     .sum_im(a0_im_s),
    .dif_re(a1_re_s),     .dif_im(a1_im_s)
  );

  radix2_bfly #(.W(IN_W)) u_s1_odd (
    .a_re  (bin_re_r[1]), .a_im  (bin_im_r[1]),
    .b_re  (bin_re_r[3]), .b_im  (bin_im_r[3]),
    .sum_re(b0_re_s),     .sum_im(b0_im_s),
    .dif_re(b1_re_s),     .dif_im(b1_im_s)
  );

  // b1 = X1 - X3 never reaches the most negative S1_W value, so the
  // negation below cannot overflow.
  assign jb1_re_s = -b1_im_s;
  assign jb1_im_s = b1_re_s;

  radix2_bfly #(.W(S1_W)) u_s2_even (
    .a_re  (a0_re_s), .a_im  (a0_im_s),
    .b_re  (b0_re_s), .b_im  (b0_im_s),
    .sum_re(x0_re_s), .sum_im(x0_im_s),
    .dif_re(x2_re_s), .dif_im(x2_im_s)
  );

  // a1 + j*b1 gives x1, a1 - j*b1 gives x3
  radix2_bfly #(.W(S1_W)) u_s2_odd (
    .a_re  (a1_re_s),  .a_im  (a1_im_s),
    .b_re  (jb1_re_s), .b_im  (jb1_im_s),
    .sum_re(x1_re_s),  .sum_im(x1_im_s),
    .dif_re(x3_re_s),  .dif_im(x3_im_s)
  );

  // Order stage-2 results by sample index and apply optional 1/N scaling.
  always_comb begin
    full_re_s = '{x0_re_s, x1_re_s, x2_re_s, x3_re_s};
    full_im_s = '{x0_im_s, x1_im_s, x2_im_s, x3_im_s};
    for (int i = 0; i < N; i++) begin
`ifdef RADIX2IFFT_SCALE_EN
      res_re_s[i] = OUT_W'(full_re_s[i] >>> 2'd2);
      res_im_s[i] = OUT_W'(full_im_s[i] >>> 2'd2);
`else
      res_re_s[i] = OUT_W'(full_re_s[i]);
      res_im_s[i] = OUT_W'(full_im_s[i]);
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------

  // Next-state and index counter decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      LOAD: begin
        if (in_fire_s) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_IDX) begin
            state_nxt_s = CALC;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      CALC: begin
        state_nxt_s = OUT;
        cnt_nxt_s   = '0;
      end
      OUT: begin
        if (out_fire_s) begin
          if (cnt_r == LAST_IDX) begin
            state_nxt_s = LOAD;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = OUT;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = LOAD;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State register and index counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Input bin capture and output buffer load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        bin_re_r[i] <= '0;
        bin_im_r[i] <= '0;
        buf_re_r[i] <= '0;
        buf_im_r[i] <= '0;
      end
    end else begin
      if (in_fire_s) begin
        bin_re_r[cnt_r] <= in_re;
        bin_im_r[cnt_r] <= in_im;
      end else begin
        bin_re_r[cnt_r] <= bin_re_r[cnt_r];
        bin_im_r[cnt_r] <= bin_im_r[cnt_r];
      end
      if (state_r == CALC) begin
        for (int i = 0; i < N; i++) begin
          buf_re_r[i] <= res_re_s[i];
          buf_im_r[i] <= res_im_s[i];
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          buf_re_r[i] <= buf_re_r[i];
          buf_im_r[i] <= buf_im_r[i];
        end
      end
    end
  end

  // Registered handshake and sample outputs. While out_valid is high and
  // out_ready is low every output register holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_re_r    <= '0;
      out_im_r    <= '0;
    end else begin
      in_ready_r <= (state_nxt_s == LOAD);
      case (state_r)
        OUT: begin
          if (!out_valid_r) begin
            // first OUT cycle: present buffer[0]
            out_valid_r <= 1'b1;
            out_re_r    <= buf_re_r[cnt_r];
            out_im_r    <= buf_im_r[cnt_r];
            out_last_r  <= (cnt_r == LAST_IDX);
          end else if (out_ready) begin
            if (cnt_r == LAST_IDX) begin
              out_valid_r <= 1'b0;
              out_re_r    <= '0;
              out_im_r    <= '0;
              out_last_r  <= 1'b0;
            end else begin
              out_valid_r <= 1'b1;
              out_re_r    <= buf_re_r[cnt_nxt_s];
              out_im_r    <= buf_im_r[cnt_nxt_s];
              out_last_r  <= (cnt_nxt_s == LAST_IDX);
            end
          end else begin
            out_valid_r <= out_valid_r;
            out_re_r    <= out_re_r;
            out_im_r    <= out_im_r;
            out_last_r  <= out_last_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_re_r    <= '0;
          out_im_r    <= '0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/radix2ifft.md
RADIX2IFFT -- requirements
Module: radix2ifft

Interface
REQ-001 SHALL have parameter IN_W, default 4, signed width of each input bin component.
REQ-002 SHALL have parameter OUT_W, default IN_W+2, signed width of each output sample component.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  bin present on in_re/in_im.
REQ-006 in_ready  output  1  block accepts a bin this cycle.
REQ-007 in_re, in_im  input  IN_W  signed bin X[k], real/imag; bins arrive in order k=0..3.
REQ-008 out_valid  output  1  time sample present on out_re/out_im.
REQ-009 out_ready  input  1  sink accepts a sample this cycle.
REQ-010 out_re, out_im  output  OUT_W  signed time sample x[n], n=0..3.
REQ-011 out_last  output  1  high with sample n=3.

Function
REQ-012 SHALL compute 4-point radix-2 inverse DFT: x[n] = sum X[k]*W^(-nk), W^-1 = +j.
REQ-013 Stage 1 SHALL form a0=X0+X2, a1=X0-X2, b0=X1+X3, b1=X1-X3.
REQ-014 Stage 2 SHALL form x0=a0+b0, x2=a0-b0, x1=(a1r-b1i)+j(a1i+b1r), x3=(a1r+b1i)+j(a1i-b1r).
REQ-015 All arithmetic SHALL be signed with sign extension; no overflow possible at OUT_W=IN_W+2.
REQ-016 FSM states: LOAD, CALC, OUT.
REQ-017 LOAD: in_ready=1; bin stored at index cnt on in_valid&&in_ready; cnt increments; after index 3 stored, go to CALC.
REQ-018 CALC: in_ready=0, out_valid=0; results registered into 4-entry output buffer; next state OUT.
REQ-019 OUT: out_valid=1, drive buffer[cnt]; cnt advances on out_valid&&out_ready; after n=3 transfers, go to LOAD with cnt=0.
REQ-020 Latency: out_valid SHALL rise on the second rising edge after the edge that captured bin 3.
REQ-021 out_re/out_im/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 in_valid while in_ready=0 SHALL be ignored (no capture, no state change).
REQ-023 in_ready and out_valid SHALL never be high in the same cycle.
REQ-024 in_re/in_im SHALL be ignored when in_valid=0.

Reset
REQ-025 On rst_n low: state=LOAD, cnt=0, in_ready=1, out_valid=0, out_last=0, out_re=out_im=0, all buffers cleared.
REQ-026 Reset mid-frame (any state) SHALL discard partial frame; first bin after release is X[0].

Configuration
REQ-027 Macro RADIX2IFFT_SCALE_EN defined: outputs SHALL be x[n] arithmetically shifted right by 2 (divide by N=4, floor), sign-extended to OUT_W.
REQ-028 Macro undefined: outputs SHALL be unscaled x[n] in full OUT_W.

Structure
REQ-029 Package radix2_pkg SHALL hold N=4, default IN_W, state enum (LOAD/CALC/OUT), and a complex sample struct type.
REQ-030 Sub-module radix2_bfly (one complex add/subtract pair, width parameterised) SHALL be instantiated for both stages; twiddle +j handled by swap/negate in radix2ifft.

Verification
REQ-031 All bins 4+0j, unscaled -> x = 16, 0, 0, 0 (imag 0); scaled -> 4, 0, 0, 0.
REQ-032 X0=4, others 0, unscaled -> all four samples 4+0j; scaled -> all 1+0j.
REQ-033 X1=4, others 0, unscaled -> 4, 0+4j, -4, 0-4j; scaled -> 1, j, -1, -j; out_last only on fourth.
REQ-034 All bins -8-8j, unscaled -> x0=-32-32j, others 0; scaled -> x0=-8-8j.
REQ-035 out_ready low 3 cycles during sample 1 -> out_valid stays high, data stable, no sample lost or repeated; in_valid pulses meanwhile ignored.
REQ-036 rst_n low after bin 2 captured, then a full new frame (X0=4) -> outputs match REQ-032 with no residue from the aborted frame.
